// File: rtl/shift_right_mc_if.sv
// Request/response bundle for the multi-cycle barrel right shifter.
// The requester drives the operands and start; the shifter returns the
// registered result together with its busy/done status.
interface shift_right_mc_if;
    logic        start;
    logic [31:0] operandA;
    logic [4:0]  shamt;
    logic        arith;
    logic [31:0] result;
    logic        busy;
    logic        done;

    modport master (
        output start,
        output operandA,
        output shamt,
        output arith,
        input  result,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  operandA,
        input  shamt,
        input  arith,
        output result,
        output busy,
        output done
    );
endinterface

// File: rtl/shift_right_mc.sv
// Multi-cycle 32-bit right shifter (logical or arithmetic).
// A request is captured, then walked through five log stages (16, 8, 4, 2, 1),
// one per cycle, so every shift takes the same time regardless of the amount.
// The final value is written to result on the last stage edge and flagged by a
// one-cycle done pulse; a new request can be accepted in that same done cycle.
module shift_right_mc (
    input  logic             clock,
    input  logic             reset,
    shift_right_mc_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    state_t      state_q,  state_d;
    logic [2:0]  stage_q,  stage_d;
    logic [31:0] data_q,   data_d;
    logic [4:0]  shamt_q,  shamt_d;
    logic        arith_q,  arith_d;
    logic [31:0] result_q, result_d;
    logic        busy_q,   busy_d;
    logic        done_q,   done_d;

    logic [4:0]  step_amt;
    logic        step_en;
    logic        fill_bit;
    logic [31:0] shifted;

    // One log stage: shift by the stage's power of two when the matching
    // shamt bit is set. For arithmetic shifts data_q[31] still holds the
    // original sign bit, because every earlier stage filled with that sign.
    always_comb begin
        step_amt = 5'd1;
        step_en  = 1'b0;
        case (stage_q)
            3'd0: begin step_amt = 5'd16; step_en = shamt_q[4]; end
            3'd1: begin step_amt = 5'd8;  step_en = shamt_q[3]; end
            3'd2: begin step_amt = 5'd4;  step_en = shamt_q[2]; end
            3'd3: begin step_amt = 5'd2;  step_en = shamt_q[1]; end
            default: begin step_amt = 5'd1; step_en = shamt_q[0]; end
        endcase
        fill_bit = arith_q & data_q[31];
        if (step_en) begin
            shifted = (data_q >> step_amt)
                    | (fill_bit ? ~(32'hFFFF_FFFF >> step_amt) : 32'h0000_0000);
        end else begin
            shifted = data_q;
        end
    end

    // Next-state logic: capture in IDLE/DONE, walk five stages in SHIFT,
    // publish the result on the final stage. busy/done are derived from the
    // next state so that they come straight out of flops.
    always_comb begin
        state_d  = state_q;
        stage_d  = stage_q;
        data_d   = data_q;
        shamt_d  = shamt_q;
        arith_d  = arith_q;
        result_d = result_q;
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    data_d  = bus.operandA;
                    shamt_d = bus.shamt;
                    arith_d = bus.arith;
                    stage_d = 3'd0;
                    state_d = SHIFT;
                end else begin
                    state_d = IDLE;
                end
            end
            SHIFT: begin
                data_d = shifted;
                if (stage_q == 3'd4) begin
                    result_d = shifted;
                    state_d  = DONE;
                end else begin
                    stage_d = stage_q + 3'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        busy_d = (state_d == SHIFT);
        done_d = (state_d == DONE);
    end

    // All state registers; reset clears everything and abandons any shift
    // in flight without touching result beyond clearing it.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= IDLE;
            stage_q  <= 3'd0;
            data_q   <= 32'h0000_0000;
            shamt_q  <= 5'd0;
            arith_q  <= 1'b0;
            result_q <= 32'h0000_0000;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            stage_q  <= stage_d;
            data_q   <= data_d;
            shamt_q  <= shamt_d;
            arith_q  <= arith_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign bus.result = result_q;
    assign bus.busy   = busy_q;
    assign bus.done   = done_q;

endmodule

// File: doc/shift_right_mc.md
SHIFT_RIGHT_MC -- requirements
Module: shift_right_mc

Interface
REQ-001 The block SHALL have no parameters; data width is fixed at 32 bits and shift amount at 5 bits.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request to begin a shift; accepted only when busy=0.
REQ-005 operandA  input  32  value to shift; sampled on the accepting edge.
REQ-006 shamt  input  5  right-shift amount 0..31; sampled on the accepting edge.
REQ-007 arith  input  1  1 selects arithmetic shift (sign fill), 0 selects logical shift (zero fill); sampled on the accepting edge.
REQ-008 result  output  32  registered shift result; valid while done=1 and held until the next result is written.
REQ-009 busy  output  1  high while a shift is in progress.
REQ-010 done  output  1  one-cycle pulse marking result valid.

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-012 In IDLE or DONE, start=1 at a rising edge SHALL capture operandA, shamt and arith into internal registers, clear the stage counter to 0 and enter SHIFT.
REQ-013 In SHIFT, start SHALL be ignored, and captured operands SHALL remain unchanged.
REQ-014 SHIFT SHALL last exactly 5 cycles, one log stage per cycle, with stage k in 0..4 shifting by 16, 8, 4, 2, 1 respectively.
REQ-015 At stage k the data register SHALL load its value shifted right by (16>>k) if captured shamt[4-k]=1, and SHALL hold otherwise.
REQ-016 Vacated high bits SHALL be filled with captured operandA[31] when arith=1, and with 0 when arith=0.
REQ-017 On the stage-4 edge, the final shifted value SHALL be written to result and the FSM SHALL enter DONE.
REQ-018 result SHALL change only on that edge and on reset.
REQ-019 busy SHALL be 1 exactly in SHIFT; done SHALL be 1 exactly in DONE.
REQ-020 Latency SHALL be fixed: start accepted at edge E gives done=1 in the cycle following edge E+5, for all shamt including 0.
REQ-021 DONE SHALL last one cycle, then go to IDLE if start=0, or accept a new request per REQ-012 if start=1 (back-to-back operation).
REQ-022 When shamt=0, result SHALL equal operandA; when shamt=31, result SHALL equal {32{operandA[31]}} for arith=1 and {31'b0, operandA[31]} for arith=0.
REQ-023 The block SHALL be functionally equivalent to operandA >> shamt (logical) and $signed(operandA) >>> shamt (arithmetic).

Reset
REQ-024 reset=1 at a rising edge SHALL force state IDLE, busy=0, done=0, result=0x00000000, stage counter 0 and internal data 0.
REQ-025 Reset SHALL take priority over start and SHALL abort any in-progress shift without writing result.
REQ-026 The first start after reset deasserts SHALL be accepted normally.

Verification
REQ-027 SRL: operandA=0x80000000, shamt=31, arith=0 -> busy high for 5 cycles, then done pulse with result=0x00000001.
REQ-028 SRA: operandA=0x80000000, shamt=4, arith=1 -> result=0xF8000000; and operandA=0x7FFFFFF0, shamt=4, arith=1 -> result=0x07FFFFFF.
REQ-029 Zero shift: operandA=0xDEADBEEF, shamt=0, either arith -> result=0xDEADBEEF, with done still 5 cycles after acceptance.
REQ-030 Start while busy: start 0x0000FF00 shamt=8 arith=0, then assert start with 0xFFFFFFFF shamt=1 during SHIFT -> second request ignored; result=0x000000FF.
REQ-031 Back-to-back: start held high -> done pulses every 6 cycles, each result matches its own captured operands.
REQ-032 Reset mid-shift: reset at the third SHIFT cycle -> next cycle busy=0, done=0, result=0; a following start with 0x00000010 shamt=4 arith=0 -> result=0x00000001.
